// File: rtl/vga_timing_rx.sv
// Receive-side video timing recovery: pixel coordinates, line/frame measurement and format lock.
// Optional per-frame pixel checksum (frame_chk/chk_valid) when VGA_TIMING_RX_CHKSUM_EN is defined.
module vga_timing_rx #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 4096,
    parameter bit          SYNC_POL    = 1'b1
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    input  logic [23:0] rgb,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        sof,
    output logic [11:0] h_total,
    output logic [11:0] h_active,
    output logic [11:0] v_total,
    output logic [11:0] v_active,
    output logic        locked,
    output logic        fmt_err
`ifdef VGA_TIMING_RX_CHKSUM_EN
    ,
    output logic [23:0] frame_chk,
    output logic        chk_valid
`endif
);

    typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hfff) ? v : v + 12'd1;
    endfunction

    // Input stage, syncs normalised to active-high
    logic        hs_q, vs_q, de_q;
    logic [23:0] rgb_q;
    logic        hs_prev_q, vs_prev_q, de_prev_q;
    logic        hs_rise, vs_rise, de_rise, de_fall;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            rgb_q     <= 24'd0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
        end else begin
            hs_q      <= (hsync == SYNC_POL);
            vs_q      <= (vsync == SYNC_POL);
            de_q      <= de;
            rgb_q     <= rgb;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            de_prev_q <= de_q;
        end
    end

    assign hs_rise = hs_q & ~hs_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;
    assign de_rise = de_q & ~de_prev_q;
    assign de_fall = ~de_q & de_prev_q;

    // Pixel path; pix_y only advances once a vsync has been seen since reset
    logic [11:0] x_cnt_q, y_cnt_q;
    logic        frame_seen_q, sof_arm_q;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pix_x        <= 12'hfff;
            pix_y        <= 12'hfff;
            pix_data     <= 24'd0;
            pix_valid    <= 1'b0;
            sof          <= 1'b0;
            x_cnt_q      <= 12'd0;
            y_cnt_q      <= 12'd0;
            frame_seen_q <= 1'b0;
            sof_arm_q    <= 1'b0;
        end else begin
            pix_valid <= de_q;
            pix_data  <= de_q ? rgb_q : 24'd0;
            pix_x     <= de_q ? (de_rise ? 12'd0 : x_cnt_q) : 12'hfff;
            pix_y     <= de_q ? y_cnt_q : 12'hfff;
            sof       <= de_q & sof_arm_q;
            if (de_q) begin
                x_cnt_q <= de_rise ? 12'd1 : sat_inc(x_cnt_q);
            end
            if (vs_rise) begin
                y_cnt_q      <= 12'd0;
                frame_seen_q <= 1'b1;
                sof_arm_q    <= 1'b1;
            end else begin
                if (de_fall && frame_seen_q) begin
                    y_cnt_q <= sat_inc(y_cnt_q);
                end
                if (de_q) begin
                    sof_arm_q <= 1'b0;
                end
            end
        end
    end

    // Timing measurement
    logic [11:0] h_cnt_q, de_cnt_q, line_cnt_q, act_cnt_q;
    logic        line_de_q;
    logic [31:0] to_cnt_q;
    logic        timeout;
    logic [11:0] h_total_d, h_active_d, v_total_d, v_active_d, act_cnt_upd;

    assign timeout = ~hs_rise && (to_cnt_q == 32'(TIMEOUT - 1));

    // Line-end accounting happens before the frame-end capture in the same cycle
    always_comb begin
        h_total_d   = h_total;
        h_active_d  = h_active;
        v_total_d   = v_total;
        v_active_d  = v_active;
        act_cnt_upd = act_cnt_q;
        if (hs_rise) begin
            h_total_d = sat_inc(h_cnt_q);
            if (de_cnt_q != 12'd0) begin
                h_active_d = de_cnt_q;
            end
            if (line_de_q) begin
                act_cnt_upd = sat_inc(act_cnt_q);
            end
        end
        if (vs_rise) begin
            v_total_d  = line_cnt_q;
            v_active_d = act_cnt_upd;
        end
        if (timeout) begin
            h_total_d  = 12'd0;
            h_active_d = 12'd0;
            v_total_d  = 12'd0;
            v_active_d = 12'd0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_total    <= 12'd0;
            h_active   <= 12'd0;
            v_total    <= 12'd0;
            v_active   <= 12'd0;
            h_cnt_q    <= 12'd0;
            de_cnt_q   <= 12'd0;
            line_cnt_q <= 12'd0;
            act_cnt_q  <= 12'd0;
            line_de_q  <= 1'b0;
            to_cnt_q   <= 32'd0;
        end else begin
            h_total  <= h_total_d;
            h_active <= h_active_d;
            v_total  <= v_total_d;
            v_active <= v_active_d;
            h_cnt_q  <= hs_rise ? 12'd0 : sat_inc(h_cnt_q);
            to_cnt_q <= (hs_rise || timeout) ? 32'd0 : to_cnt_q + 32'd1;
            if (hs_rise) begin
                de_cnt_q  <= {11'd0, de_q};
                line_de_q <= de_q;
            end else if (de_q) begin
                de_cnt_q  <= sat_inc(de_cnt_q);
                line_de_q <= 1'b1;
            end
            if (vs_rise) begin
                line_cnt_q <= hs_rise ? 12'd1 : 12'd0;
                act_cnt_q  <= 12'd0;
            end else if (hs_rise) begin
                line_cnt_q <= sat_inc(line_cnt_q);
                act_cnt_q  <= act_cnt_upd;
            end
        end
    end

    // Lock FSM
    state_e      state_q;
    logic [47:0] ref_q, meas_d;
    logic [3:0]  match_q;

    assign meas_d = {h_total_d, h_active_d, v_total_d, v_active_d};

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q <= StSearch;
            ref_q   <= 48'd0;
            match_q <= 4'd0;
            locked  <= 1'b0;
            fmt_err <= 1'b0;
        end else begin
            fmt_err <= 1'b0;
            if (timeout) begin
                state_q <= StSearch;
                match_q <= 4'd0;
                locked  <= 1'b0;
                fmt_err <= locked;
            end else begin
                case (state_q)
                    StSearch: begin
                        if (vs_rise) state_q <= StMeasure;
                    end
                    StMeasure: begin
                        if (vs_rise) begin
                            ref_q   <= meas_d;
                            match_q <= 4'd0;
                            state_q <= StVerify;
                        end
                    end
                    StVerify: begin
                        if (vs_rise) begin
                            if (meas_d == ref_q) begin
                                match_q <= match_q + 4'd1;
                                if (32'(match_q) + 32'd1 >= LOCK_FRAMES) begin
                                    state_q <= StLocked;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                ref_q   <= meas_d;
                                match_q <= 4'd0;
                            end
                        end
                    end
                    StLocked: begin
                        if ((vs_rise && (meas_d != ref_q)) ||
                            (hs_rise && (h_total_d != ref_q[47:36]))) begin
                            fmt_err <= 1'b1;
                            locked  <= 1'b0;
                            ref_q   <= meas_d;
                            match_q <= 4'd0;
                            state_q <= StVerify;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

`ifdef VGA_TIMING_RX_CHKSUM_EN
    logic [23:0] acc_q, acc_sum;

    assign acc_sum = acc_q + (pix_valid ? pix_data : 24'd0);

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            acc_q     <= 24'd0;
            frame_chk <= 24'd0;
            chk_valid <= 1'b0;
        end else begin
            chk_valid <= vs_rise;
            if (vs_rise) begin
                frame_chk <= acc_sum;
                acc_q     <= 24'd0;
            end else begin
                acc_q <= acc_sum;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a reduced 40x20-clock raster (24x12 active).
// Checksum checks are included when VGA_TIMING_RX_CHKSUM_EN is defined.
module tb_vga_timing_rx;

    localparam int H_TOT  = 40;
    localparam int H_SYNC = 4;
    localparam int H_ACT0 = 10;
    localparam int H_ACT  = 24;
    localparam int V_TOT  = 20;
    localparam int V_SYNC = 2;
    localparam int V_ACT0 = 5;
    localparam int V_ACT  = 12;

    logic        vga_clk = 1'b0;
    logic        sys_rst;
    logic        hsync, vsync, de;
    logic [23:0] rgb;
    logic [11:0] pix_x, pix_y, h_total, h_active, v_total, v_active;
    logic [23:0] pix_data;
    logic        pix_valid, sof, locked, fmt_err;
`ifdef VGA_TIMING_RX_CHKSUM_EN
    logic [23:0] frame_chk;
    logic        chk_valid;
`endif

    vga_timing_rx dut (
        .vga_clk   (vga_clk),
        .sys_rst   (sys_rst),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .rgb       (rgb),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .sof       (sof),
        .h_total   (h_total),
        .h_active  (h_active),
        .v_total   (v_total),
        .v_active  (v_active),
        .locked    (locked),
        .fmt_err   (fmt_err)
`ifdef VGA_TIMING_RX_CHKSUM_EN
        ,
        .frame_chk (frame_chk),
        .chk_valid (chk_valid)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_errors = 0;
    int fmt_cnt  = 0;
    int fmt_base;

    bit gen_on   = 1'b0;
    bit gen_stop = 1'b0;
    bit rgb_one  = 1'b0;
    int short_v  = -1;
    int gh = 0, gv = 0;
    int drv_h = -1, drv_v = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Return at the first negedge where the generator is driving position (h,v)
    task automatic wait_pos(input int h, input int v);
        int n = 0;
        @(negedge vga_clk);
        while (!(drv_h == h && drv_v == v) && n < 3000) begin
            @(negedge vga_clk);
            n++;
        end
        if (n >= 3000) check_eq("wait_pos_timeout", 32'(n), 32'd0);
    endtask

    // Raster generator; vsync rises together with hsync at the start of line 0
    initial begin
        hsync = 1'b0;
        vsync = 1'b0;
        de    = 1'b0;
        rgb   = 24'd0;
        forever begin
            @(posedge vga_clk);
            #2;
            if (gen_on && !gen_stop) begin
                hsync = (gh < H_SYNC);
                vsync = (gv < V_SYNC);
                de    = (gh >= H_ACT0) && (gh < H_ACT0 + H_ACT) &&
                        (gv >= V_ACT0) && (gv < V_ACT0 + V_ACT);
                if (de) rgb = rgb_one ? 24'h000001 : {8'h5a, 8'(gv), 8'(gh)};
                else    rgb = 24'hdeadbe;
                drv_h = gh;
                drv_v = gv;
                gh++;
                if (gh >= ((gv == short_v) ? H_TOT - 1 : H_TOT)) begin
                    gh = 0;
                    gv = (gv + 1) % V_TOT;
                end
            end else begin
                hsync = 1'b0;
                vsync = 1'b0;
                de    = 1'b0;
                rgb   = 24'd0;
                drv_h = -1;
                drv_v = -1;
                gh    = 0;
                gv    = 0;
            end
        end
    end

    always @(negedge vga_clk) begin
        if (fmt_err === 1'b1) fmt_cnt <= fmt_cnt + 1;
    end

    initial begin
        sys_rst = 1'b1;
        repeat (5) @(posedge vga_clk);
        @(negedge vga_clk);
        check_eq("rst_pix_x", 32'(pix_x), 32'hfff);
        check_eq("rst_pix_y", 32'(pix_y), 32'hfff);
        check_eq("rst_pix_data", 32'(pix_data), 32'h0);
        check_eq("rst_flags", {28'd0, pix_valid, sof, locked, fmt_err}, 32'h0);
        check_eq("rst_h_total", 32'(h_total), 32'h0);
        check_eq("rst_v_active", 32'(v_active), 32'h0);

        // Acquire lock: it must appear right after the 4th vsync rise
        sys_rst = 1'b0;
        gen_on  = 1'b1;
        repeat (3) wait_pos(0, 0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("locked_after_vs3", {31'd0, locked}, 32'd0);
        wait_pos(0, 0);
        @(negedge vga_clk);
        check_eq("locked_before_vs4", {31'd0, locked}, 32'd0);
        @(negedge vga_clk);
        check_eq("locked_at_vs4", {31'd0, locked}, 32'd1);

        // First pixel of the frame
        wait_pos(10, 5);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("first_x", 32'(pix_x), 32'd0);
        check_eq("first_y", 32'(pix_y), 32'd0);
        check_eq("first_sof", {31'd0, sof}, 32'd1);
        check_eq("first_valid", {31'd0, pix_valid}, 32'd1);
        check_eq("first_data", 32'(pix_data), 32'h5a050a);
        @(negedge vga_clk);
        check_eq("second_x", 32'(pix_x), 32'd1);
        check_eq("second_sof", {31'd0, sof}, 32'd0);
        wait_pos(10, 6);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("line1_y", 32'(pix_y), 32'd1);

        // Last pixel and following blanking
        wait_pos(33, 16);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("last_x", 32'(pix_x), 32'd23);
        check_eq("last_y", 32'(pix_y), 32'd11);
        check_eq("last_data", 32'(pix_data), 32'h5a1021);
        @(negedge vga_clk);
        check_eq("blank_x", 32'(pix_x), 32'hfff);
        check_eq("blank_y", 32'(pix_y), 32'hfff);
        check_eq("blank_data", 32'(pix_data), 32'h0);
        check_eq("blank_valid", {31'd0, pix_valid}, 32'd0);
        check_eq("meas_h_total", 32'(h_total), 32'd40);
        check_eq("meas_h_active", 32'(h_active), 32'd24);
        check_eq("meas_v_total", 32'(v_total), 32'd20);
        check_eq("meas_v_active", 32'(v_active), 32'd12);
        check_eq("no_fmt_err_yet", 32'(fmt_cnt), 32'd0);

        // One short line (39 clocks) on line 8 of the next frame
        fmt_base = fmt_cnt;
        short_v  = 8;
        wait_pos(0, 9);
        short_v  = -1;
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("short_fmt_err", {31'd0, fmt_err}, 32'd1);
        check_eq("short_locked", {31'd0, locked}, 32'd0);
        check_eq("short_h_total", 32'(h_total), 32'd39);
        @(negedge vga_clk);
        check_eq("short_fmt_err_pulse", {31'd0, fmt_err}, 32'd0);
        wait_pos(0, 0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("relock_vs0", {31'd0, locked}, 32'd0);
        wait_pos(0, 0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("relock_vs1", {31'd0, locked}, 32'd0);
        wait_pos(0, 0);
        @(negedge vga_clk);
        check_eq("relock_vs2_pre", {31'd0, locked}, 32'd0);
        @(negedge vga_clk);
        check_eq("relock_vs2", {31'd0, locked}, 32'd1);
        check_eq("short_fmt_count", 32'(fmt_cnt - fmt_base), 32'd1);

        // Stream stops mid-frame: timeout after 4096 clocks without hsync
        wait_pos(20, 8);
        gen_stop = 1'b1;
        fmt_base = fmt_cnt;
        repeat (4000) @(negedge vga_clk);
        check_eq("to_still_locked", {31'd0, locked}, 32'd1);
        check_eq("to_no_err_early", 32'(fmt_cnt - fmt_base), 32'd0);
        repeat (300) @(negedge vga_clk);
        check_eq("to_locked", {31'd0, locked}, 32'd0);
        check_eq("to_fmt_count", 32'(fmt_cnt - fmt_base), 32'd1);
        check_eq("to_h_total", 32'(h_total), 32'd0);
        check_eq("to_h_active", 32'(h_active), 32'd0);
        check_eq("to_v_total", 32'(v_total), 32'd0);
        check_eq("to_v_active", 32'(v_active), 32'd0);

        // Synchronous reset mid-line while de is high
        gen_stop = 1'b0;
        repeat (2) wait_pos(0, 0);
        wait_pos(15, 7);
        sys_rst = 1'b1;
        @(posedge vga_clk);
        #1;
        check_eq("mrst_pix_x", 32'(pix_x), 32'hfff);
        check_eq("mrst_pix_y", 32'(pix_y), 32'hfff);
        check_eq("mrst_pix_data", 32'(pix_data), 32'h0);
        check_eq("mrst_valid", {31'd0, pix_valid}, 32'd0);
        check_eq("mrst_h_total", 32'(h_total), 32'd0);
        sys_rst = 1'b0;
        wait_pos(10, 8);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("stray_y", 32'(pix_y), 32'd0);
        check_eq("stray_x", 32'(pix_x), 32'd0);
        check_eq("stray_valid", {31'd0, pix_valid}, 32'd1);
        wait_pos(10, 5);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("resume_y0", 32'(pix_y), 32'd0);
        check_eq("resume_sof", {31'd0, sof}, 32'd1);
        wait_pos(10, 6);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("resume_y1", 32'(pix_y), 32'd1);

`ifdef VGA_TIMING_RX_CHKSUM_EN
        // 288 active pixels of value 1 per frame
        rgb_one = 1'b1;
        wait_pos(0, 0);
        wait_pos(0, 0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        check_eq("chk_valid", {31'd0, chk_valid}, 32'd1);
        check_eq("frame_chk", 32'(frame_chk), 32'h000120);
        @(negedge vga_clk);
        check_eq("chk_valid_pulse", {31'd0, chk_valid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
